// File: rtl/demux_pkg.sv
// Shared types and sizes for the 1-to-8 demultiplexer.
// Lane count, select width and the lane/select vector types.
package demux_pkg;

  localparam int DEMUX_N = 8;
  localparam int SEL_W   = $clog2(DEMUX_N);

  typedef logic [SEL_W-1:0]   sel_t;
  typedef logic [DEMUX_N-1:0] lanes_t;

endpackage

// File: rtl/decoder_3to8.sv
// Combinational 3-to-8 decoder with enable; output is one-hot or zero.
// Ports: en (enable), sel (lane index), onehot (decoded lanes).
import demux_pkg::*;

module decoder_3to8 (
  input  logic   en,
  input  sel_t   sel,
  output lanes_t onehot
);

  // if() on an X/Z condition takes the false path, so unknown
  // en or sel leaves the lanes at zero in simulation.
  always_comb begin
    onehot = '0;
    if (en) begin
      for (int i = 0; i < DEMUX_N; i++) begin
        if (sel == sel_t'(i)) onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/demux_1to8.sv
// 1-to-8 demux: D is routed to lane sel of Y, all other lanes low.
// Ports: clk, rst_n (async, active-low), D, sel, Y[7:0].
import demux_pkg::*;

module demux_1to8 #(
  parameter bit     OUT_REG = 1'b1,
  parameter lanes_t RST_VAL = 8'h00
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   D,
  input  sel_t   sel,
  output lanes_t Y
);

  lanes_t y_next;

  decoder_3to8 u_dec (
    .en     (D),
    .sel    (sel),
    .onehot (y_next)
  );

  generate
    if (OUT_REG) begin : g_reg
      lanes_t y_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) y_q <= RST_VAL;
        else        y_q <= y_next;
      end

      assign Y = y_q;

`ifndef SYNTHESIS
      a_rst_clear: assert property (
        @(negedge clk) !rst_n |-> (Y == RST_VAL)
      );
`endif
    end else begin : g_comb
      assign Y = y_next;
    end
  endgenerate

`ifndef SYNTHESIS
  a_onehot0: assert property (
    @(posedge clk) $onehot0(Y)
  );
`endif

endmodule

// File: tb/tb_demux_1to8.sv
// Self-checking bench for demux_1to8: registered and combinational
// variants against a behavioural routing model, random plus directed.
module tb_demux_1to8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       d = 1'b0;
  logic [2:0] sel = 3'd0;
  logic [7:0] y_reg;
  logic [7:0] y_comb;

  int total = 0;
  int bad = 0;
  bit run_chk = 1'b0;

  always #5 clk = ~clk;

  demux_1to8 #(.OUT_REG(1'b1), .RST_VAL(8'h00)) dut_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .D     (d),
    .sel   (sel),
    .Y     (y_reg)
  );

  demux_1to8 #(.OUT_REG(1'b0), .RST_VAL(8'h00)) dut_comb (
    .clk   (clk),
    .rst_n (rst_n),
    .D     (d),
    .sel   (sel),
    .Y     (y_comb)
  );

  // Routing rule: a set bit lands at lane sel, otherwise nothing.
  function automatic logic [7:0] route(logic dv, logic [2:0] s);
    logic [7:0] one;
    one = 8'h01;
    return dv ? (one << s) : 8'h00;
  endfunction

  // Expected registered output: last sampled routing, cleared by reset.
  logic [7:0] exp_reg = 8'h00;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_reg <= 8'h00;
    else        exp_reg <= route(d, sel);
  end

  task automatic check(string name, logic [7:0] act, logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %02h expected %02h at %0t",
               name, act, req, $time);
    end
  endtask

  // Every-cycle compare, away from the active edge.
  always @(negedge clk) begin
    if (run_chk) begin
      check("model_reg", y_reg, exp_reg);
      check("model_comb", y_comb, route(d, sel));
    end
  end

  task automatic drive(logic dv, logic [2:0] s);
    @(negedge clk);
    #2;
    d = dv;
    sel = s;
  endtask

  task automatic edge_then;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] walk [8] = '{8'h01, 8'h02, 8'h04, 8'h08,
                           8'h10, 8'h20, 8'h40, 8'h80};

  initial begin
    // Reset held with D=1, sel=5 across several edges.
    d = 1'b1;
    sel = 3'b101;
    repeat (3) begin
      edge_then();
      check("reset_hold", y_reg, 8'h00);
    end
    run_chk = 1'b1;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    edge_then();
    check("reset_release", y_reg, 8'b0010_0000);

    // Basic routing.
    drive(1'b1, 3'b000);
    edge_then();
    check("basic_sel0", y_reg, 8'b0000_0001);
    drive(1'b1, 3'b001);
    edge_then();
    check("basic_sel1", y_reg, 8'b0000_0010);

    // Walking sweep with D=1.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 3'(i));
      edge_then();
      check("sweep_d1", y_reg, walk[i]);
    end

    // Zero data on every lane.
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 3'(i));
      edge_then();
      check("sweep_d0", y_reg, 8'h00);
    end

    // Select change between edges must not show until the next edge.
    drive(1'b1, 3'b010);
    edge_then();
    check("stable_pre", y_reg, 8'h04);
    #1;
    sel = 3'b110;
    #1;
    check("stable_mid", y_reg, 8'h04);
    edge_then();
    check("stable_post", y_reg, 8'h40);

    // Mid-cycle reset pulse clears immediately.
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst", y_reg, 8'h00);
    #1;
    rst_n = 1'b1;
    edge_then();
    check("after_rst", y_reg, 8'h40);

    // Combinational variant, no clock edge involved.
    @(negedge clk);
    #1;
    d = 1'b1;
    sel = 3'b011;
    #1;
    check("comb_sel3", y_comb, 8'b0000_1000);
    rst_n = 1'b0;
    #1;
    check("comb_rst", y_comb, 8'b0000_1000);
    check("comb_rst_reg", y_reg, 8'h00);
    #1;
    rst_n = 1'b1;

    // Randomised traffic with occasional reset pulses.
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
      if ($urandom_range(0, 31) == 0) begin
        #1;
        rst_n = 1'b0;
        #1;
        check("rand_rst", y_reg, 8'h00);
        rst_n = 1'b1;
      end
    end

    @(negedge clk);
    run_chk = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
